// File: rtl/w_input_conditioner.sv
// Synchronizes and debounces a bouncy pin into the detector's w input.
// Optional rising-edge pulse on w_rise when W_COND_RISE_PULSE_EN is defined.
module w_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw_in,
  output logic w,
  output logic w_rise,
  output logic busy
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (CNT_W < 31 && (1 << CNT_W) <= DEBOUNCE_CYCLES - 1)
  begin : g_bad_cnt
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit FAST = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   rise_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // w, busy and the pulse are registered alongside the state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= STABLE_LO;
      cnt    <= '0;
      w      <= 1'b0;
      busy   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      unique case (state)
        STABLE_LO: begin
          if (s) begin
            if (FAST) begin
              state  <= STABLE_HI;
              w      <= 1'b1;
              rise_q <= 1'b1;
            end else begin
              state <= WAIT_HI;
              cnt   <= ONE;
              busy  <= 1'b1;
            end
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state <= STABLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == LAST) begin
            state  <= STABLE_HI;
            cnt    <= '0;
            w      <= 1'b1;
            busy   <= 1'b0;
            rise_q <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            if (FAST) begin
              state <= STABLE_LO;
              w     <= 1'b0;
            end else begin
              state <= WAIT_LO;
              cnt   <= ONE;
              busy  <= 1'b1;
            end
          end
        end
        WAIT_LO: begin
          if (s) begin
            state <= STABLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == LAST) begin
            state <= STABLE_LO;
            cnt   <= '0;
            w     <= 1'b0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
      endcase
    end
  end

`ifdef W_COND_RISE_PULSE_EN
  assign w_rise = rise_q;
`else
  assign w_rise = 1'b0;
  logic unused_rise;
  assign unused_rise = rise_q;
`endif

endmodule
